uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte producers, such as the ALU result interface and status/debug sources. It selects one pending requester, latches its byte, and issues a single-cycle start to the transmitter. It then holds off all other requesters until the transmitter reports the frame done, and reports acceptance and completion back to each requester.

---
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter
// among NREQ byte producers. One requester is granted at a time and its
// byte is latched. The transmitter gets a one-cycle start pulse, and the
// arbiter then waits for the frame-done pulse before it grants again.
// Optional build macro UART_ARB_TIMEOUT_EN adds a WAIT-state watchdog
// that aborts a frame after TIMEOUT_CYC clocks with no done pulse.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int DBIT        = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*DBIT-1:0] i_data,
    input  logic                 i_done_tx,
    output logic                 o_tx_start,
    output logic [DBIT-1:0]      o_tx_data,
    output logic [NREQ-1:0]      o_ack,
    output logic [NREQ-1:0]      o_done,
    output logic [IDW-1:0]       o_grant_id,
    output logic                 o_busy,
    output logic                 o_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [IDW-1:0]    last_ptr_reg, last_ptr_next;
    logic [IDW-1:0]    grant_id_reg, grant_id_next;
    logic [DBIT-1:0]   tx_data_reg, tx_data_next;
    logic              tx_start_reg, tx_start_next;
    logic [NREQ-1:0]   ack_reg, ack_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic              found;
    int                idx;

    // Per-requester byte lanes, unpacked so the winner can be indexed directly
    logic [DBIT-1:0]   data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign data_arr[gi] = i_data[gi*DBIT +: DBIT];
        end
    endgenerate

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]       wd_cnt_reg, wd_cnt_next;
    logic              timeout_reg, timeout_next;
`else
    // The watchdog limit only matters when the watchdog is built in
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // State, pointers and every output are registered here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            last_ptr_reg <= IDW'(NREQ - 1);
            grant_id_reg <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            ack_reg      <= '0;
            done_reg     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_reg   <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            last_ptr_reg <= last_ptr_next;
            grant_id_reg <= grant_id_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            ack_reg      <= ack_next;
            done_reg     <= done_next;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_reg   <= wd_cnt_next;
            timeout_reg  <= timeout_next;
`endif
        end
    end

    // Next-state logic: round-robin search in IDLE, pulse generation, WAIT exit
    always_comb begin
        state_next    = state_reg;
        last_ptr_next = last_ptr_reg;
        grant_id_next = grant_id_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;
        ack_next      = '0;
        done_next     = '0;
        found         = 1'b0;
        idx           = 0;
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_next   = wd_cnt_reg;
        timeout_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                // Start just after the last served requester, so it ranks last
                for (int k = 1; k <= NREQ; k++) begin
                    idx = int'(last_ptr_reg) + k;
                    if (idx >= NREQ) begin
                        idx = idx - NREQ;
                    end
                    if (!found && i_req[idx]) begin
                        found         = 1'b1;
                        grant_id_next = idx[IDW-1:0];
                        tx_data_next  = data_arr[idx];
                        ack_next[idx] = 1'b1;
                    end
                end
                if (found) begin
                    tx_start_next = 1'b1;
                    state_next    = LAUNCH;
                end
            end
            LAUNCH: begin
                // Start/ack are already on the wire this cycle; done is ignored here
                state_next = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                wd_cnt_next = '0;
`endif
            end
            WAIT: begin
                if (i_done_tx) begin
                    // A done in the same cycle as the watchdog limit takes precedence
                    done_next[grant_id_reg] = 1'b1;
                    last_ptr_next           = grant_id_reg;
                    state_next              = IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_cnt_reg == 16'(TIMEOUT_CYC - 1)) begin
                    timeout_next  = 1'b1;
                    last_ptr_next = grant_id_reg;
                    state_next    = IDLE;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 16'd1;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_tx_start = tx_start_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_ack      = ack_reg;
    assign o_done     = done_reg;
    assign o_grant_id = grant_id_reg;
    assign o_busy     = (state_reg != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign o_timeout  = timeout_reg;
`else
    assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=4, DBIT=8, TIMEOUT_CYC=50).
// The watchdog section runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        done_tx;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NREQ(4), .IDW(2), .DBIT(8), .TIMEOUT_CYC(50)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
        .i_done_tx(done_tx), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_ack(ack), .o_done(done), .o_grant_id(grant_id),
        .o_busy(busy), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the rising edge; inputs change at the same point
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a start pulse, check grant, optionally drop the
    // request in LAUNCH, then pulse done a few cycles later and check o_done
    task automatic do_txn(input int exp_id, input logic [7:0] exp_data, input bit drop);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << exp_id;
        n = 0;
        while (!tx_start && n < 10) begin
            tick();
            n++;
        end
        chk("txn_start", {31'd0, tx_start}, 32'd1);
        chk("txn_ack", {28'd0, ack}, {28'd0, oh});
        chk("txn_grant", {30'd0, grant_id}, exp_id);
        chk("txn_data", {24'd0, tx_data}, {24'd0, exp_data});
        $display("txn: grant=%0d data=%02h ack=%b", grant_id, tx_data, ack);
        if (drop) req[exp_id] = 1'b0;
        tick();
        chk("txn_start_1cyc", {31'd0, tx_start}, 32'd0);
        tick();
        tick();
        chk("txn_data_hold", {24'd0, tx_data}, {24'd0, exp_data});
        done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        chk("txn_done", {28'd0, done}, {28'd0, oh});
        chk("txn_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; data = 32'h0; done_tx = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);

        // 1: single request from requester 2, done 20 cycles later
        data = 32'h00A5_0000;
        req  = 4'b0100;
        tick();
        chk("t1_start", {31'd0, tx_start}, 32'd1);
        chk("t1_ack", {28'd0, ack}, 32'h4);
        chk("t1_data", {24'd0, tx_data}, 32'hA5);
        chk("t1_grant", {30'd0, grant_id}, 32'd2);
        req = 4'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t1_wait_busy", {31'd0, busy}, 32'd1);
        chk("t1_wait_nodone", {28'd0, done}, 32'd0);
        done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        chk("t1_done", {28'd0, done}, 32'h4);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_done_1cyc", {28'd0, done}, 32'd0);

        // 2: all four requests held from reset; rotation 0,1,2,3
        rst = 1'b1; data = 32'h1312_1110; req = 4'b1111;
        tick();
        rst = 1'b0;
        do_txn(0, 8'h10, 1'b1);
        do_txn(1, 8'h11, 1'b1);
        do_txn(2, 8'h12, 1'b1);
        do_txn(3, 8'h13, 1'b1);
        tick();
        chk("t2_quiet", {31'd0, busy}, 32'd0);

        // 3: requester 1 holds, requester 3 joins after first grant -> 1,3,1,3
        data = 32'h2300_2100;
        req  = 4'b0010;
        tick();
        req[3] = 1'b1;
        do_txn(1, 8'h21, 1'b0);
        do_txn(3, 8'h23, 1'b0);
        do_txn(1, 8'h21, 1'b0);
        do_txn(3, 8'h23, 1'b0);
        req = 4'b0;
        tick();

        // 4: done ignored in IDLE and LAUNCH, then reset in WAIT
        done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        chk("t4_idle_done", {28'd0, done}, 32'd0);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        data = 32'h0000_005A;
        req  = 4'b0001;
        tick();
        chk("t4_launch", {31'd0, tx_start}, 32'd1);
        req = 4'b0; done_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        chk("t4_launch_done", {28'd0, done}, 32'd0);
        tick();
        tick();
        chk("t4_still_wait", {31'd0, busy}, 32'd1);
        chk("t4_no_done", {28'd0, done}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        chk("t4_rst_data", {24'd0, tx_data}, 32'd0);
        chk("t4_rst_grant", {30'd0, grant_id}, 32'd0);
        chk("t4_rst_done", {28'd0, done}, 32'd0);
        data = 32'h0000_6B5A;
        req  = 4'b0011;
        do_txn(0, 8'h5A, 1'b1);
        req = 4'b0;
        tick();

        // 5: requester drops in LAUNCH; byte still goes out and completes
        data = 32'h00C3_0000;
        req  = 4'b0100;
        do_txn(2, 8'hC3, 1'b1);
        tick();

`ifdef UART_ARB_TIMEOUT_EN
        // 6: no done ever arrives; watchdog aborts 50 cycles into WAIT
        data = 32'h7700_0000;
        req  = 4'b1000;
        tick();
        chk("t6_start", {31'd0, tx_start}, 32'd1);
        req = 4'b0011;
        tick();
        for (int i = 0; i < 49; i++) tick();
        chk("t6_pre_timeout", {31'd0, timeout}, 32'd0);
        chk("t6_pre_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t6_timeout", {31'd0, timeout}, 32'd1);
        chk("t6_no_done", {28'd0, done}, 32'd0);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("t6_timeout_1cyc", {31'd0, timeout}, 32'd0);
        chk("t6_next_start", {31'd0, tx_start}, 32'd1);
        chk("t6_next_grant", {30'd0, grant_id}, 32'd0);
        req = 4'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`else
        chk("timeout_tied", {31'd0, timeout}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
